// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered 4-bit adder among NREQ requesters.
// Latency: request seen in IDLE at T -> issue at T+1 -> response valid at T+2+ADD_LAT.
// Backpressure: rsp_ready_i low holds the response; no new grant or issue until it is consumed.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid_i/req_a_i/req_b_i  per-requester valid and packed 4-bit operands (slot i at [4i+3:4i])
//   req_ready_o                one-hot accept strobe, asserted only in the issue cycle
//   add_valid_o/add_a_o/add_b_o  issue strobe and operands to the shared adder
//   add_c_i                    sum returned by the adder ADD_LAT cycles after issue
//   rsp_valid_o/rsp_ready_i    response handshake
//   rsp_c_o/rsp_id_o           captured sum and owning requester index
//   busy_o                     high whenever a transaction is in progress
module adder_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = $clog2(NREQ),
    parameter int ADD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [4*NREQ-1:0] req_a_i,
    input  logic [4*NREQ-1:0] req_b_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic              add_valid_o,
    output logic [3:0]        add_a_o,
    output logic [3:0]        add_b_o,
    input  logic [6:0]        add_c_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [6:0]        rsp_c_o,
    output logic [IDW-1:0]    rsp_id_o,
    output logic              busy_o
);

    localparam int CNTW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  ptr_d;
    logic [IDW-1:0]  winner_q;
    logic [CNTW-1:0] cnt_q;
    logic [6:0]      rsp_c_q;
    logic [IDW-1:0]  rsp_id_q;

    logic            pick_vld;
    logic [IDW-1:0]  pick_idx;
    int              scan_idx;

    // First valid requester at or above ptr_q, wrapping past NREQ-1 back to 0.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!pick_vld && req_valid_i[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = IDW'(scan_idx);
            end
        end
    end

    // Pointer moves just past the requester being served so it goes to the back of the line.
    assign ptr_d = (winner_q == IDW'(NREQ - 1)) ? '0 : winner_q + 1'b1;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_vld) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: winner latch, round-robin pointer, latency counter, response capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q    <= '0;
            winner_q <= '0;
            cnt_q    <= '0;
            rsp_c_q  <= '0;
            rsp_id_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        winner_q <= pick_idx;
                    end
                end
                ISSUE: begin
                    ptr_q <= ptr_d;
                    cnt_q <= CNTW'(ADD_LAT - 1);
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        rsp_c_q  <= add_c_i;
                        rsp_id_q <= winner_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic: adder port and accept strobe are live only during ISSUE.
    always_comb begin
        req_ready_o = '0;
        add_valid_o = 1'b0;
        add_a_o     = 4'd0;
        add_b_o     = 4'd0;
        rsp_valid_o = 1'b0;
        busy_o      = (state_q != IDLE);
        case (state_q)
            ISSUE: begin
                add_valid_o           = 1'b1;
                req_ready_o[winner_q] = 1'b1;
                add_a_o               = req_a_i[{winner_q, 2'b00} +: 4];
                add_b_o               = req_b_i[{winner_q, 2'b00} +: 4];
            end
            RESP: begin
                rsp_valid_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign rsp_c_o  = rsp_c_q;
    assign rsp_id_o = rsp_id_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter: one ADD_LAT=1 instance and one ADD_LAT=3 instance,
// each driving a registered adder of matching latency. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_adder_rr_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ADD_LAT = 1 instance
    logic [3:0]  req_valid;
    logic [15:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic        add_valid;
    logic [3:0]  add_a, add_b;
    logic [6:0]  add_c;
    logic        rsp_valid, rsp_ready;
    logic [6:0]  rsp_c;
    logic [1:0]  rsp_id;
    logic        busy;

    // ADD_LAT = 3 instance
    logic [3:0]  req_valid3;
    logic [15:0] req_a3, req_b3;
    logic [3:0]  req_ready3;
    logic        add_valid3;
    logic [3:0]  add_a3, add_b3;
    logic [6:0]  add_c3;
    logic        rsp_valid3, rsp_ready3;
    logic [6:0]  rsp_c3;
    logic [1:0]  rsp_id3;
    logic        busy3;

    adder_rr_arbiter #(.NREQ(4), .IDW(2), .ADD_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b), .req_ready_o(req_ready),
        .add_valid_o(add_valid), .add_a_o(add_a), .add_b_o(add_b), .add_c_i(add_c),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_c_o(rsp_c), .rsp_id_o(rsp_id),
        .busy_o(busy)
    );

    adder_rr_arbiter #(.NREQ(4), .IDW(2), .ADD_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid3), .req_a_i(req_a3), .req_b_i(req_b3), .req_ready_o(req_ready3),
        .add_valid_o(add_valid3), .add_a_o(add_a3), .add_b_o(add_b3), .add_c_i(add_c3),
        .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3), .rsp_c_o(rsp_c3), .rsp_id_o(rsp_id3),
        .busy_o(busy3)
    );

    // Registered adders with 1 and 3 cycles of latency.
    logic [6:0] sum1_q;
    logic [6:0] sum3_q [3];
    always @(posedge clk) begin
        sum1_q    <= {3'b000, add_a} + {3'b000, add_b};
        sum3_q[0] <= {3'b000, add_a3} + {3'b000, add_b3};
        sum3_q[1] <= sum3_q[0];
        sum3_q[2] <= sum3_q[1];
    end
    assign add_c  = sum1_q;
    assign add_c3 = sum3_q[2];

    int vectors     = 0;
    int miscompares = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0; req_valid3 = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        vectors++; if ({add_valid, add_a, add_b} !== 9'd0) begin miscompares++; $display("FAIL reset_add: got %b/%0d/%0d want 0/0/0", add_valid, add_a, add_b); end
        vectors++; if ({rsp_valid, rsp_c, rsp_id} !== 10'd0) begin miscompares++; $display("FAIL reset_rsp: got %b/%0d/%0d want 0/0/0", rsp_valid, rsp_c, rsp_id); end
        vectors++; if ({busy3, rsp_valid3, add_valid3} !== 3'b000) begin miscompares++; $display("FAIL reset_lat3: got %b want 000", {busy3, rsp_valid3, add_valid3}); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        tick();                                   // cycle T
        req_a[11:8] = 4'd7; req_b[11:8] = 4'd9; req_valid = 4'b0100; rsp_ready = 1'b1;
        tick();                                   // T+1 ISSUE
        vectors++; if (add_valid !== 1'b1) begin miscompares++; $display("FAIL single_add_valid: got %b want 1", add_valid); end
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL single_req_ready: got %b want 0100", req_ready); end
        vectors++; if (add_a !== 4'd7 || add_b !== 4'd9) begin miscompares++; $display("FAIL single_operands: got %0d,%0d want 7,9", add_a, add_b); end
        tick();                                   // T+2 WAIT
        req_valid = 4'b0000;
        vectors++; if (add_valid !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL single_wait: got add_valid=%b rsp_valid=%b busy=%b want 0,0,1", add_valid, rsp_valid, busy); end
        tick();                                   // T+3 RESP
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
        vectors++; if (rsp_c !== 7'd16 || rsp_id !== 2'd2) begin miscompares++; $display("FAIL single_rsp_data: got c=%0d id=%0d want c=16 id=2", rsp_c, rsp_id); end
        tick();                                   // T+4 IDLE
        vectors++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_idle: got busy=%b rsp_valid=%b want 0,0", busy, rsp_valid); end
    endtask

    task automatic test_contention();
        logic [3:0] exp_rdy;
        int j, ph;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[4*i +: 4] = 4'(i);
            req_b[4*i +: 4] = 4'd10;
        end
        req_valid = 4'b1111;
        for (int k = 1; k <= 16; k++) begin
            tick();
            j = (k - 1) / 4;
            ph = (k - 1) % 4;
            exp_rdy = 4'b0001 << j;
            if (ph == 0) begin
                vectors++; if (add_valid !== 1'b1 || req_ready !== exp_rdy) begin miscompares++; $display("FAIL contention_grant%0d: got add_valid=%b req_ready=%b want 1,%b", j, add_valid, req_ready, exp_rdy); end
            end else if (ph == 1) begin
                req_valid[j] = 1'b0;
            end else if (ph == 2) begin
                vectors++; if (rsp_valid !== 1'b1 || rsp_c !== 7'(10 + j) || rsp_id !== 2'(j)) begin miscompares++; $display("FAIL contention_rsp%0d: got v=%b c=%0d id=%0d want 1,%0d,%0d", j, rsp_valid, rsp_c, rsp_id, 10 + j, j); end
            end else begin
                vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL contention_idle%0d: got busy=%b want 0", j, busy); end
            end
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_rdy;
        int j, ph;
        tick();
        req_a[3:0] = 4'd1; req_b[3:0] = 4'd2;
        req_a[15:12] = 4'd4; req_b[15:12] = 4'd4;
        req_valid = 4'b1001;
        for (int k = 1; k <= 16; k++) begin
            tick();
            j = (k - 1) / 4;
            ph = (k - 1) % 4;
            exp_rdy = (j % 2 == 0) ? 4'b0001 : 4'b1000;
            if (ph == 0) begin
                vectors++; if (req_ready !== exp_rdy) begin miscompares++; $display("FAIL fairness_grant%0d: got %b want %b", j, req_ready, exp_rdy); end
            end else if (ph == 2) begin
                vectors++; if (rsp_c !== ((j % 2 == 0) ? 7'd3 : 7'd8)) begin miscompares++; $display("FAIL fairness_rsp%0d: got %0d want %0d", j, rsp_c, (j % 2 == 0) ? 3 : 8); end
            end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_backpressure();
        tick();                                   // T, pointer at 0
        req_a[7:4] = 4'd15; req_b[7:4] = 4'd15; req_valid = 4'b0010; rsp_ready = 1'b0;
        tick();                                   // T+1 ISSUE
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
        tick();                                   // T+2 WAIT
        req_a[11:8] = 4'd3; req_b[11:8] = 4'd4; req_valid = 4'b0100;
        for (int s = 0; s < 5; s++) begin
            tick();                               // T+3 .. T+7 stalled in RESP
            vectors++; if (rsp_valid !== 1'b1 || rsp_c !== 7'd30 || rsp_id !== 2'd1) begin miscompares++; $display("FAIL bp_hold%0d: got v=%b c=%0d id=%0d want 1,30,1", s, rsp_valid, rsp_c, rsp_id); end
            vectors++; if (add_valid !== 1'b0 || req_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_no_issue%0d: got add_valid=%b req_ready=%b want 0,0000", s, add_valid, req_ready); end
        end
        rsp_ready = 1'b1;
        tick();                                   // IDLE after handshake
        vectors++; if (busy !== 1'b0 || add_valid !== 1'b0) begin miscompares++; $display("FAIL bp_idle: got busy=%b add_valid=%b want 0,0", busy, add_valid); end
        tick();                                   // req2 ISSUE
        vectors++; if (add_valid !== 1'b1 || req_ready !== 4'b0100 || add_a !== 4'd3 || add_b !== 4'd4) begin miscompares++; $display("FAIL bp_next_issue: got v=%b rdy=%b a=%0d b=%0d want 1,0100,3,4", add_valid, req_ready, add_a, add_b); end
        tick();
        req_valid = 4'b0000;
        tick();
        vectors++; if (rsp_valid !== 1'b1 || rsp_c !== 7'd7 || rsp_id !== 2'd2) begin miscompares++; $display("FAIL bp_next_rsp: got v=%b c=%0d id=%0d want 1,7,2", rsp_valid, rsp_c, rsp_id); end
        tick();
    endtask

    task automatic test_reset_mid();
        tick();                                   // T, pointer at 3
        req_a[3:0] = 4'd2; req_b[3:0] = 4'd3; req_valid = 4'b0001;
        tick();                                   // ISSUE, pointer becomes 1
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL rmid_grant: got %b want 0001", req_ready); end
        tick();                                   // WAIT
        req_valid = 4'b0000;
        #1 reset = 1'b1;
        #1;
        vectors++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || add_valid !== 1'b0 || req_ready !== 4'b0000) begin miscompares++; $display("FAIL rmid_async: got busy=%b rsp_valid=%b add_valid=%b rdy=%b want all 0", busy, rsp_valid, add_valid, req_ready); end
        vectors++; if (rsp_c !== 7'd0 || rsp_id !== 2'd0) begin miscompares++; $display("FAIL rmid_rsp_regs: got c=%0d id=%0d want 0,0", rsp_c, rsp_id); end
        tick();
        reset = 1'b0;
        for (int s = 0; s < 4; s++) begin
            tick();
            vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rmid_quiet%0d: got rsp_valid=%b busy=%b want 0,0", s, rsp_valid, busy); end
        end
        req_a[3:0] = 4'd1; req_b[3:0] = 4'd1; req_a[7:4] = 4'd2; req_b[7:4] = 4'd2;
        req_valid = 4'b0011;
        tick();
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL rmid_ptr_reset: got %b want 0001", req_ready); end
        tick();
        req_valid[0] = 1'b0;
        tick();
        vectors++; if (rsp_c !== 7'd2 || rsp_id !== 2'd0) begin miscompares++; $display("FAIL rmid_rsp0: got c=%0d id=%0d want 2,0", rsp_c, rsp_id); end
        tick();
        tick();
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL rmid_grant1: got %b want 0010", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        vectors++; if (rsp_c !== 7'd4 || rsp_id !== 2'd1) begin miscompares++; $display("FAIL rmid_rsp1: got c=%0d id=%0d want 4,1", rsp_c, rsp_id); end
        tick();
    endtask

    task automatic test_lat3();
        tick();                                   // T
        req_a3[3:0] = 4'd8; req_b3[3:0] = 4'd5; req_valid3 = 4'b0001; rsp_ready3 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 2) req_valid3 = 4'b0000;
            vectors++; if (add_valid3 !== (k == 1)) begin miscompares++; $display("FAIL lat3_issue_t%0d: got %b want %b", k, add_valid3, (k == 1)); end
            vectors++; if (rsp_valid3 !== (k == 5)) begin miscompares++; $display("FAIL lat3_rsp_valid_t%0d: got %b want %b", k, rsp_valid3, (k == 5)); end
            if (k == 5) begin
                vectors++; if (rsp_c3 !== 7'd13 || rsp_id3 !== 2'd0) begin miscompares++; $display("FAIL lat3_rsp_data: got c=%0d id=%0d want 13,0", rsp_c3, rsp_id3); end
            end
            if (k == 6) begin
                vectors++; if (busy3 !== 1'b0) begin miscompares++; $display("FAIL lat3_idle: got %b want 0", busy3); end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        req_valid3 = '0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_lat3();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adder_rr_arbiter.md
# adder_rr_arbiter

Round-robin arbiter and sequencer that shares one registered 4-bit adder between NREQ requesters. Each requester presents operands with a valid/ready handshake. The block issues one add at a time to the adder, waits the adder's latency, captures the sum, and returns it with the requester index on a valid/ready response channel. It sits between the requester clients and the single adder instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, $clog2(NREQ), requester index width
- ADD_LAT, 1, adder latency in cycles from the issue edge to a valid sum (1..4)
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- req_valid  input  NREQ  per-requester request valid
- req_a  input  4*NREQ  packed operand A; requester i uses bits [4i+3:4i]
- req_b  input  4*NREQ  packed operand B; same packing
- req_ready  output  NREQ  one-hot accept strobe
- add_valid  output  1  issue strobe to the adder
- add_a  output  4  operand A to the adder
- add_b  output  4  operand B to the adder
- add_c  input  7  sum returned by the adder
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumer ready
- rsp_c  output  7  captured sum
- rsp_id  output  IDW  index of the requester that owns rsp_c
- busy  output  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid bit is set, latch the winner and go to ISSUE.
  - The winner is the first set bit scanning upward from ptr, wrapping NREQ-1 to 0.
- ISSUE (exactly 1 cycle):
  - add_valid=1.
  - add_a/add_b carry the winner's operands.
  - req_ready[winner]=1.
  - ptr <= (winner+1) mod NREQ.
  - Next state is WAIT, with the latency counter loaded to ADD_LAT-1.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter is 0, capture rsp_c<=add_c and rsp_id<=winner, then go to RESP.
- RESP:
  - Hold rsp_valid=1 with rsp_c and rsp_id stable until rsp_ready=1.
  - On the handshake cycle, go to IDLE.
- Requester protocol:
  - Once req_valid[i] is raised, req_valid[i] and its operands stay stable until req_ready[i].
  - The block does not check this.
- A requester whose valid rises while the block is busy waits. It is not lost.
- Outside ISSUE, add_valid=0 and add_a/add_b=0.
- Width rule: sum ≤ 30, so add_c[6:5] is always 0. rsp_c passes all 7 bits unmodified.
- Only one transaction is in flight. No new issue happens before the previous response is consumed.

## Timing
- Reset (asynchronous, effective immediately):
  - state=IDLE, ptr=0, winner=0.
  - req_ready=0, add_valid=0, add_a=0, add_b=0.
  - rsp_valid=0, rsp_c=0, rsp_id=0, busy=0.
- Reset mid-transaction aborts it. No response is produced and the granted request is considered consumed.
- Latency with ADD_LAT=1 and rsp_ready held high:
  - req_valid seen in IDLE at cycle T.
  - ISSUE at T+1.
  - WAIT at T+2.
  - rsp_valid at T+3.
  - IDLE at T+4.
- General case: rsp_valid first asserts at T+2+ADD_LAT.
- Minimum transaction period is 3+ADD_LAT cycles.
- A requester that is still valid after ptr passes it is not served again until every other valid requester has been served once.
- A rsp_ready low stall holds the FSM in RESP. During the stall, req_ready stays 0 and no issue occurs.
- req_valid changes during WAIT/RESP have no effect until IDLE.

## Test plan
- Single request:
  - Stimulus: reset, then req_valid=4'b0100 with a2=7, b2=9, rsp_ready=1.
  - Response: add_valid and req_ready[2] pulse at T+1; rsp_valid at T+3 with rsp_c=16, rsp_id=2; busy low again at T+4.
- Simultaneous contention:
  - Stimulus: all 4 valid with a_i=i, b_i=10, each dropped after its grant.
  - Response: grants in order 0,1,2,3; responses carry sums 10,11,12,13; the four transactions complete in 16 cycles.
- Round-robin fairness:
  - Stimulus: req0 and req3 held valid continuously.
  - Response: grants alternate 0,3,0,3; req0 is never granted twice in a row.
- Backpressure:
  - Stimulus: a=15, b=15 from req1, rsp_ready=0 for 5 cycles.
  - Response: rsp_valid held with rsp_c=30, rsp_id=1 stable; no add_valid pulse during the stall even though req2 is valid; req2 is issued only after the handshake.
- Reset mid-operation:
  - Stimulus: assert reset during WAIT.
  - Response: all outputs 0 immediately; no rsp_valid afterwards; ptr=0, so the next contention between req0 and req1 grants req0.
- ADD_LAT=3 build:
  - Stimulus: a=8, b=5.
  - Response: rsp_valid at T+5 with rsp_c=13.
